// File: rtl/ram_arb_pkg.sv
// Shared definitions for the ram_8x4 arbiter: FSM encoding, requester ids
// and default RAM geometry.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. The priority bit names the
// requester that wins a tie; a lone request wins regardless.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_id
);

  // Pick the winner: tie goes to the priority holder.
  always_comb begin
    gnt_valid = req_a | req_b;
    if (req_a && req_b) begin
      gnt_id = prio;
    end else if (req_b) begin
      gnt_id = REQ_B;
    end else begin
      gnt_id = REQ_A;
    end
  end

endmodule

// File: rtl/ram_8x4_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port RAM between two
// req/ack requesters. One transaction takes IDLE -> ACCESS -> RESP; the ack
// pulse lands in the following IDLE cycle, which can already grant again.
//
// state  | meaning
// IDLE   | waiting for a request; ack pulse of the previous transaction visible here
// ACCESS | RAM driven with latched address/data; writes commit at the closing edge
// RESP   | read data arrives from the RAM and is loaded at the closing edge
module ram_8x4_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  arb_state_t        state;
  logic              prio;
  logic              lat_id;
  logic              lat_we;
  logic              req_a_m;
  logic              req_b_m;
  logic              gnt_valid;
  logic              gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A requester still holding req during its own ack cycle must not be
  // granted a second time for the same request.
  assign req_a_m = req_a & ~ack_a;
  assign req_b_m = req_b & ~ack_b;

  rr_arb2 u_rr_arb2 (
    .req_a     (req_a_m),
    .req_b     (req_b_m),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Mux the winning requester's fields for latching.
  always_comb begin
    sel_we    = (gnt_id == REQ_B) ? we_b    : we_a;
    sel_addr  = (gnt_id == REQ_B) ? addr_b  : addr_a;
    sel_wdata = (gnt_id == REQ_B) ? wdata_b : wdata_a;
  end

  // Sequencer FSM; every output is registered. ram_addr/ram_din double as
  // the latched address/data and hold their value between transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= REQ_A;
      lat_id   <= REQ_A;
      lat_we   <= 1'b0;
      ram_en   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      busy     <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            lat_id   <= gnt_id;
            lat_we   <= sel_we;
            ram_en   <= sel_we;
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata;
            prio     <= ~gnt_id;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (!lat_we) begin
            if (lat_id == REQ_B) rdata_b <= ram_dout;
            else                 rdata_a <= ram_dout;
          end
          if (lat_id == REQ_B) ack_b <= 1'b1;
          else                 ack_a <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_8x4_arbiter.sv
// Bench for ram_8x4_arbiter with a behavioural 8x4 RAM (synchronous write,
// registered read) and an ack scoreboard.
module tb_ram_8x4_arbiter;

  localparam int AW = 3;
  localparam int DW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            chk;
  } op_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            chk;
    int            rcyc;
  } exp_t;

  typedef struct {
    bit            id;
    int            cyc;
    logic [DW-1:0] rdata;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          ack_a, ack_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  ram_8x4_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  obs_t obs[$];
  int   both_cnt = 0;
  always @(negedge clk) begin
    if (ack_a) obs.push_back('{1'b0, cyc, rdata_a});
    if (ack_b) obs.push_back('{1'b1, cyc, rdata_b});
    if (ack_a && ack_b) both_cnt = both_cnt + 1;
  end

  int   checks = 0;
  int   errors = 0;
  int   obs_rd = 0;
  op_t  ops_a[$];
  op_t  ops_b[$];
  exp_t exp_a[$];
  exp_t exp_b[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req_a = 1'b0;
    req_b = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Requesters hold req until their ack, drop it for the ack cycle, then
  // present their next operation. Expectations are queued as each req rises.
  task automatic drive(output int r0);
    int ia = 0;
    int ib = 0;
    int budget = 300;
    r0 = cyc;
    while ((ia < ops_a.size() || ib < ops_b.size() || req_a || req_b) && budget > 0) begin
      if (req_a) begin
        if (ack_a) req_a = 1'b0;
      end else if (ia < ops_a.size()) begin
        we_a = ops_a[ia].we; addr_a = ops_a[ia].addr; wdata_a = ops_a[ia].wdata;
        req_a = 1'b1;
        exp_a.push_back('{ops_a[ia].rdata, ops_a[ia].chk, cyc});
        ia++;
      end
      if (req_b) begin
        if (ack_b) req_b = 1'b0;
      end else if (ib < ops_b.size()) begin
        we_b = ops_b[ib].we; addr_b = ops_b[ib].addr; wdata_b = ops_b[ib].wdata;
        req_b = 1'b1;
        exp_b.push_back('{ops_b[ib].rdata, ops_b[ib].chk, cyc});
        ib++;
      end
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL drive_timeout: acks outstanding a=%0d b=%0d, required none", exp_a.size(), exp_b.size());
      req_a = 1'b0;
      req_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    int r0;
    int n0;
    obs_t o;
    exp_t e;
    rst = 1'b1;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    tick(); tick();
    checks++;
    if ({ack_a, ack_b, ram_en, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: ack_a,ack_b,ram_en,busy=%b required 0000", {ack_a, ack_b, ram_en, busy});
    end
    checks++;
    if ({ram_addr, ram_din, rdata_a, rdata_b} !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h din=%h ra=%h rb=%h required all 0", ram_addr, ram_din, rdata_a, rdata_b);
    end
    rst = 1'b0;
    tick();
    ops_a.delete(); ops_b.delete();
    ops_a.push_back('{1'b1, 3'd5, 4'h6, 4'h0, 1'b0});
    drive(r0);
    tick();
    we_a = 1'b1; addr_a = 3'd5; wdata_a = 4'hF; req_a = 1'b1;
    n0 = obs.size();
    tick();
    checks++;
    if (ram_en !== 1'b1 || busy !== 1'b1 || ram_addr !== 3'd5) begin
      errors++; $display("FAIL reset_access_entry: ram_en=%b busy=%b addr=%0d required 1 1 5", ram_en, busy, ram_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ram_en !== 1'b0) begin
      errors++; $display("FAIL reset_async_en: ram_en=%b required 0", ram_en);
    end
    checks++;
    if ({ack_a, ack_b, busy, ram_addr, ram_din, rdata_a, rdata_b} !== '0) begin
      errors++; $display("FAIL reset_async_outputs: ack=%b%b busy=%b addr=%h din=%h ra=%h rb=%h required all 0",
                         ack_a, ack_b, busy, ram_addr, ram_din, rdata_a, rdata_b);
    end
    req_a = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (obs.size() != n0) begin
      errors++; $display("FAIL reset_no_ack: acks seen %0d required 0", obs.size() - n0);
    end
    ops_a.delete();
    ops_a.push_back('{1'b0, 3'd5, 4'h0, 4'h6, 1'b1});
    drive(r0);
    while (obs_rd < obs.size()) begin
      o = obs[obs_rd]; obs_rd++;
      if ((o.id ? exp_b.size() : exp_a.size()) == 0) begin
        checks++; errors++; $display("FAIL reset_unexpected_ack: id=%0d cyc=%0d required no ack", o.id, o.cyc);
        continue;
      end
      e = o.id ? exp_b.pop_front() : exp_a.pop_front();
      checks++;
      if (o.cyc - e.rcyc !== 3) begin
        errors++; $display("FAIL reset_latency: %0d cycles required 3", o.cyc - e.rcyc);
      end
      if (e.chk) begin
        checks++;
        if (o.rdata !== e.rdata) begin
          errors++; $display("FAIL reset_read_addr5: rdata=%h required %h", o.rdata, e.rdata);
        end
      end
    end
    checks++;
    if (exp_a.size() + exp_b.size() != 0) begin
      errors++; $display("FAIL reset_missing_ack: outstanding %0d required 0", exp_a.size() + exp_b.size());
    end
  endtask

  task automatic test_single_writer();
    int r0;
    obs_t o;
    exp_t e;
    ops_a.delete(); ops_b.delete();
    for (int i = 0; i < 4; i++) begin
      op_t w;
      w.we = 1'b1; w.addr = AW'(i); w.wdata = DW'(i + 1); w.rdata = '0; w.chk = 1'b0;
      ops_a.push_back(w);
    end
    for (int i = 0; i < 4; i++) begin
      op_t r;
      r.we = 1'b0; r.addr = AW'(i); r.wdata = '0; r.rdata = DW'(i + 1); r.chk = 1'b1;
      ops_a.push_back(r);
    end
    drive(r0);
    while (obs_rd < obs.size()) begin
      o = obs[obs_rd]; obs_rd++;
      checks++;
      if (o.id !== 1'b0 || exp_a.size() == 0) begin
        errors++; $display("FAIL single_unexpected_ack: id=%0d cyc=%0d required A with pending op", o.id, o.cyc);
        continue;
      end
      e = exp_a.pop_front();
      checks++;
      if (o.cyc - e.rcyc !== 3) begin
        errors++; $display("FAIL single_latency: %0d cycles required 3", o.cyc - e.rcyc);
      end
      if (e.chk) begin
        checks++;
        if (o.rdata !== e.rdata) begin
          errors++; $display("FAIL single_rdata_a: got %h required %h", o.rdata, e.rdata);
        end
      end
    end
    checks++;
    if (exp_a.size() != 0) begin
      errors++; $display("FAIL single_missing_ack: outstanding %0d required 0", exp_a.size());
    end
  endtask

  // Both requesters start together from reset: acks must alternate A,B,...
  // every third cycle starting three cycles after the request.
  task automatic test_alternating(input string name, input int n_exp);
    int r0;
    int n;
    int b0;
    obs_t o;
    exp_t e;
    b0 = both_cnt;
    drive(r0);
    n = obs.size() - obs_rd;
    checks++;
    if (n != n_exp) begin
      errors++; $display("FAIL %s_ack_count: got %0d required %0d", name, n, n_exp);
    end
    for (int k = 0; k < n; k++) begin
      o = obs[obs_rd + k];
      checks++;
      if (o.id !== k[0] || o.cyc != r0 + 3 * (k + 1)) begin
        errors++; $display("FAIL %s_order: ack %0d id=%0d cyc=%0d required id=%0d cyc=%0d",
                           name, k, o.id, o.cyc - r0, k[0], 3 * (k + 1));
      end
      if ((o.id ? exp_b.size() : exp_a.size()) != 0) begin
        e = o.id ? exp_b.pop_front() : exp_a.pop_front();
        if (e.chk) begin
          checks++;
          if (o.rdata !== e.rdata) begin
            errors++; $display("FAIL %s_rdata: ack %0d got %h required %h", name, k, o.rdata, e.rdata);
          end
        end
      end
    end
    obs_rd = obs.size();
    exp_a.delete(); exp_b.delete();
    checks++;
    if (both_cnt != b0) begin
      errors++; $display("FAIL %s_dual_ack: %0d cycles with both acks required 0", name, both_cnt - b0);
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    ops_a.delete(); ops_b.delete();
    ops_a.push_back('{1'b1, 3'd7, 4'hA, 4'h0, 1'b0});
    ops_b.push_back('{1'b0, 3'd7, 4'h0, 4'hA, 1'b1});
    test_alternating("simultaneous", 2);
  endtask

  task automatic test_fairness();
    pulse_reset();
    ops_a.delete(); ops_b.delete();
    for (int i = 1; i <= 3; i++) begin
      op_t w;
      op_t r;
      w.we = 1'b1; w.addr = 3'd6; w.wdata = DW'(i); w.rdata = '0;     w.chk = 1'b0;
      r.we = 1'b0; r.addr = 3'd6; r.wdata = '0;     r.rdata = DW'(i); r.chk = 1'b1;
      ops_a.push_back(w);
      ops_b.push_back(r);
    end
    test_alternating("fairness", 6);
  endtask

  task automatic test_isolation();
    int r0;
    obs_t o;
    exp_t e;
    ops_a.delete(); ops_b.delete();
    ops_a.push_back('{1'b1, 3'd4, 4'h9, 4'h0, 1'b0});
    ops_a.push_back('{1'b0, 3'd4, 4'h0, 4'h9, 1'b1});
    drive(r0);
    ops_a.delete();
    ops_b.push_back('{1'b0, 3'd2, 4'h0, 4'h3, 1'b1});
    drive(r0);
    while (obs_rd < obs.size()) begin
      o = obs[obs_rd]; obs_rd++;
      if ((o.id ? exp_b.size() : exp_a.size()) == 0) begin
        checks++; errors++; $display("FAIL isolation_unexpected_ack: id=%0d required none", o.id);
        continue;
      end
      e = o.id ? exp_b.pop_front() : exp_a.pop_front();
      if (e.chk) begin
        checks++;
        if (o.rdata !== e.rdata) begin
          errors++; $display("FAIL isolation_rdata: id=%0d got %h required %h", o.id, o.rdata, e.rdata);
        end
      end
    end
    checks++;
    if (rdata_a !== 4'h9 || rdata_b !== 4'h3) begin
      errors++; $display("FAIL isolation_hold: rdata_a=%h rdata_b=%h required 9 3", rdata_a, rdata_b);
    end
  endtask

  task automatic test_idle();
    int n0;
    bit bad;
    n0 = obs.size();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ram_en !== 1'b0 || busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || obs.size() != n0) begin
      errors++; $display("FAIL idle_quiet: activity=%0d acks=%0d required 0 0", bad, obs.size() - n0);
    end
  endtask

  initial begin
    test_reset();
    test_single_writer();
    test_simultaneous();
    test_fairness();
    test_isolation();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
